// File: rtl/l2_word_responder.sv
// Responder end of the cache-to-L2 word interface: word-addressed backing store that
// services one LOAD or STORE per handshake and pulses req_fulfilled after a fixed latency.
`timescale 1ns/1ps

package xentry_pkg;
    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        STORE = 2'b01
    } memory_operation_e;
endpackage

module l2_word_responder
    import xentry_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int MEM_WORDS      = 1024,
    parameter int ACCESS_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  memory_operation_e     req_type,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [WORD_WIDTH-1:0] req_store_word,
    output logic                  req_fulfilled,
    output logic [WORD_WIDTH-1:0] req_loaded_word,
    input  logic                  preload_en,
    input  logic [ADDR_WIDTH-1:0] preload_address,
    input  logic [WORD_WIDTH-1:0] preload_word
);

    localparam int OFFSET_BITS = $clog2(WORD_WIDTH / 8);
    localparam int INDEX_BITS  = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESPOND
    } state_e;

    typedef logic [INDEX_BITS-1:0] index_t;

    state_e                  state, state_next;
    logic [7:0]              count, count_next;
    memory_operation_e       cap_type;
    index_t                  cap_index;
    logic [WORD_WIDTH-1:0]   cap_store_word;
    logic [WORD_WIDTH-1:0]   read_word;
    logic [WORD_WIDTH-1:0]   mem [MEM_WORDS];

    logic                    capture;
    logic                    preload_write;
    logic                    store_write;
    logic                    enter_respond;
    index_t                  req_index;
    index_t                  preload_index;
    index_t                  read_index;
    logic [WORD_WIDTH-1:0]   read_data;
    logic                    mem_we;
    index_t                  mem_waddr;
    logic [WORD_WIDTH-1:0]   mem_wdata;
    logic                    unused_addr_bits;

    // Byte offset is dropped and high bits alias into the store.
    assign req_index        = req_address[OFFSET_BITS +: INDEX_BITS];
    assign preload_index    = preload_address[OFFSET_BITS +: INDEX_BITS];
    assign unused_addr_bits = ^{req_address, preload_address};

    always_comb begin
        state_next      = state;
        count_next      = count;
        capture         = 1'b0;
        preload_write   = 1'b0;
        store_write     = 1'b0;
        req_fulfilled   = 1'b0;
        req_loaded_word = '0;
        case (state)
            ST_IDLE: begin
                preload_write = preload_en;
                if (req_valid) begin
                    capture    = 1'b1;
                    count_next = 8'(ACCESS_LATENCY - 1);
                    state_next = (ACCESS_LATENCY == 1) ? ST_RESPOND : ST_BUSY;
                end
            end
            ST_BUSY: begin
                count_next = count - 8'd1;
                if (count == 8'd1) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                req_fulfilled = 1'b1;
                if (cap_type == LOAD) begin
                    req_loaded_word = read_word;
                end
                store_write = (cap_type == STORE);
                state_next  = ST_IDLE;
            end
            default: begin
                state_next      = state_e'(2'bxx);
                count_next      = 'x;
                req_fulfilled   = 1'bx;
                req_loaded_word = 'x;
            end
        endcase
    end

    // The read is registered on the edge entering ST_RESPOND; with a single-cycle latency
    // that edge is also the capture edge, so a same-index preload must be forwarded.
    assign enter_respond = (state_next == ST_RESPOND) && (state != ST_RESPOND);
    assign read_index    = capture ? req_index : cap_index;
    assign read_data     = (capture && preload_write && (preload_index == req_index))
                         ? preload_word : mem[read_index];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            count          <= 8'd0;
            cap_type       <= LOAD;
            cap_index      <= '0;
            cap_store_word <= '0;
            read_word      <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (capture) begin
                cap_type       <= req_type;
                cap_index      <= req_index;
                cap_store_word <= req_store_word;
            end
            if (enter_respond) begin
                read_word <= read_data;
            end
        end
    end

    // Preload (IDLE only) and STORE commit (RESPOND only) never coincide: one write port.
    assign mem_we    = !reset && (preload_write || store_write);
    assign mem_waddr = store_write ? cap_index : preload_index;
    assign mem_wdata = store_write ? cap_store_word : preload_word;

    // NOTE: the backing store has no reset; clearing it would force a flop-based array
    // instead of a RAM, and its contents are defined by preload/STORE traffic anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    illegal_req_type_a: assert property (
        @(posedge clk) disable iff (reset)
        (state == ST_IDLE && req_valid) |-> (req_type inside {LOAD, STORE})
    );

endmodule

// File: tb/tb_l2_word_responder.sv
// Scoreboard bench for l2_word_responder: a latency-3 and a latency-1 instance, directed
// requests push expected (cycle, data) pairs; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_l2_word_responder;
    import xentry_pkg::*;

    typedef struct {
        int          cycle;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid       [2];
    memory_operation_e req_type        [2];
    logic [31:0]       req_address     [2];
    logic [31:0]       req_store_word  [2];
    logic              req_fulfilled   [2];
    logic [31:0]       req_loaded_word [2];
    logic              preload_en      [2];
    logic [31:0]       preload_address [2];
    logic [31:0]       preload_word    [2];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   next_free [2];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_word_responder #(.ACCESS_LATENCY(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_type(req_type[0]),
        .req_address(req_address[0]), .req_store_word(req_store_word[0]),
        .req_fulfilled(req_fulfilled[0]), .req_loaded_word(req_loaded_word[0]),
        .preload_en(preload_en[0]), .preload_address(preload_address[0]),
        .preload_word(preload_word[0])
    );

    l2_word_responder #(.ACCESS_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_type(req_type[1]),
        .req_address(req_address[1]), .req_store_word(req_store_word[1]),
        .req_fulfilled(req_fulfilled[1]), .req_loaded_word(req_loaded_word[1]),
        .preload_en(preload_en[1]), .preload_address(preload_address[1]),
        .preload_word(preload_word[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation; otherwise outputs stay quiet.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (req_fulfilled[d] === 1'b1) begin
                    if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pulse dut%0d at cycle %0d: got pulse, expected none", d, cyc);
                    end else begin
                        exp_t e;
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("pulse_cycle_dut%0d", d), 32'(cyc), 32'(e.cycle));
                        check($sformatf("load_data_dut%0d", d), req_loaded_word[d], e.data);
                    end
                end else begin
                    check($sformatf("fulfilled_low_dut%0d", d), 32'(req_fulfilled[d]), 32'd0);
                    check($sformatf("idle_data_zero_dut%0d", d), req_loaded_word[d], 32'd0);
                end
            end
        end
    end

    // All drivers are called just after a negedge.
    task automatic start_req(input int d, input memory_operation_e t, input logic [31:0] a,
                             input logic [31:0] w, input logic [31:0] exp);
        int tcap;
        exp_t e;
        tcap              = (cyc >= next_free[d]) ? cyc : next_free[d];
        e.cycle           = tcap + lat(d);
        e.data            = exp;
        req_valid[d]      = 1'b1;
        req_type[d]       = t;
        req_address[d]    = a;
        req_store_word[d] = w;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        next_free[d] = e.cycle + 1;
    endtask

    task automatic wait_pulse(input int d);
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            preload_en[d] = 1'b0;
            if (req_fulfilled[d] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL pulse_timeout dut%0d at cycle %0d: got no pulse, expected one", d, cyc);
        end
    endtask

    task automatic do_req(input int d, input memory_operation_e t, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] exp);
        start_req(d, t, a, w, exp);
        wait_pulse(d);
        req_valid[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload(input int d, input logic [31:0] a, input logic [31:0] w);
        preload_en[d]      = 1'b1;
        preload_address[d] = a;
        preload_word[d]    = w;
        @(negedge clk);
        preload_en[d] = 1'b0;
    endtask

    task automatic burst(input int d, input logic [31:0] base);
        for (int i = 0; i < 4; i++) preload(d, base + 32'(4 * i), 32'hC0DE_0000 + 32'(i) + 32'(d << 8));
        start_req(d, LOAD, base, 32'd0, 32'hC0DE_0000 + 32'(d << 8));
        for (int i = 0; i < 4; i++) begin
            wait_pulse(d);
            if (i < 3) start_req(d, LOAD, base + 32'(4 * (i + 1)), 32'd0,
                                 32'hC0DE_0000 + 32'(i + 1) + 32'(d << 8));
        end
        req_valid[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;       req_type[d] = LOAD;
            req_address[d] = '0;       req_store_word[d] = '0;
            preload_en[d] = 1'b0;      preload_address[d] = '0;
            preload_word[d] = '0;      next_free[d] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset_fulfilled", 32'(req_fulfilled[0]), 32'd0);
        check("reset_loaded_word", req_loaded_word[0], 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Basic LOAD latency, STORE/LOAD, byte offset and aliasing.
        preload(0, 32'h14, 32'hDEAD_BEEF);
        do_req(0, LOAD, 32'h14, 32'd0, 32'hDEAD_BEEF);
        do_req(0, STORE, 32'h40, 32'h1234_5678, 32'd0);
        do_req(0, LOAD, 32'h40, 32'd0, 32'h1234_5678);
        do_req(0, LOAD, 32'h1040, 32'd0, 32'h1234_5678);
        do_req(0, LOAD, 32'h43, 32'd0, 32'h1234_5678);

        // Cache-line bursts: spacing LATENCY+1 enforced by expected pulse cycles.
        burst(0, 32'h100);
        burst(1, 32'h200);

        // Reset while a STORE to idx 7 is in flight: it must be discarded.
        preload(0, 32'h1C, 32'hA5A5_A5A5);
        req_valid[0] = 1'b1; req_type[0] = STORE;
        req_address[0] = 32'h1C; req_store_word[0] = 32'hFFFF_0000;
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        next_free[0] = 0;
        next_free[1] = 0;
        do_req(0, LOAD, 32'h1C, 32'd0, 32'hA5A5_A5A5);

        // req_valid dropped after capture still completes; preload in BUSY is ignored.
        preload(0, 32'h24, 32'h1111_1111);
        start_req(0, LOAD, 32'h24, 32'd0, 32'h1111_1111);
        @(negedge clk);
        req_valid[0] = 1'b0;
        preload_en[0] = 1'b1; preload_address[0] = 32'h24; preload_word[0] = 32'h2222_2222;
        wait_pulse(0);
        @(negedge clk);
        do_req(0, LOAD, 32'h24, 32'd0, 32'h1111_1111);

        // Preload and capture in the same IDLE cycle.
        for (int d = 0; d < 2; d++) begin
            preload_en[d] = 1'b1; preload_address[d] = 32'h78; preload_word[d] = 32'h5A5A_0000 + 32'(d);
            do_req(d, LOAD, 32'h78, 32'd0, 32'h5A5A_0000 + 32'(d));
            preload_en[d] = 1'b1; preload_address[d] = 32'h7C; preload_word[d] = 32'h0000_0001;
            do_req(d, STORE, 32'h7C, 32'h0000_0002, 32'd0);
            do_req(d, LOAD, 32'h7C, 32'd0, 32'h0000_0002);
        end

        repeat (5) @(negedge clk);
        check("queue0_drained", 32'(exp_q0.size()), 32'd0);
        check("queue1_drained", 32'(exp_q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
